// File: rtl/suma_serie_nib_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and nibble width.
package suma_serie_nib_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/suma_serie_nib_if.sv
// Operand/handshake/result bundle between the datapath and the serial adder.
interface suma_serie_nib_if #(
  parameter int unsigned NIB = 4
);
  import suma_serie_nib_pkg::*;

  localparam int unsigned W = NIB_W * NIB;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/suma_serie_nib_sum4.sv
// Existing 4-bit ripple-carry adder stage reused by the serial sequencer.
module sum4 (
  output logic [3:0] o_sum,
  output logic       o_carry,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin
);

  always_comb begin
    logic c;
    c     = i_cin;
    o_sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_carry = c;
  end

endmodule

// File: rtl/suma_serie_nib.sv
// Multi-nibble adder: feeds sum4 one nibble per clock, LSB first, with a
// registered carry chain and a start/busy/done handshake.
module suma_serie_nib
  import suma_serie_nib_pkg::*;
#(
  parameter int unsigned NIB = 4
) (
  input  logic             clk,
  input  logic             reset,
  suma_serie_nib_if.slave  bus
);

  localparam int unsigned W  = NIB_W * NIB;
  localparam int unsigned CW = $clog2(NIB);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_psum;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_sign_a;
  logic            r_sign_b;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [NIB_W-1:0] w_nsum;
  logic             w_ncarry;
  logic [W-1:0]     w_psum_next;

  sum4 u_sum4 (w_nsum, w_ncarry, r_a[NIB_W-1:0], r_b[NIB_W-1:0], r_carry);

  // New nibble enters at the top so after NIB shifts it lands in place.
  assign w_psum_next = {w_nsum, r_psum[W-1:NIB_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_psum   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_carry  <= bus.cin;
            r_sign_a <= bus.a[W-1];
            r_sign_b <= bus.b[W-1];
            r_psum   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= {{NIB_W{1'b0}}, r_a[W-1:NIB_W]};
          r_b     <= {{NIB_W{1'b0}}, r_b[W-1:NIB_W]};
          r_carry <= w_ncarry;
          r_psum  <= w_psum_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NIB - 1)) begin
            r_sum   <= w_psum_next;
            r_cout  <= w_ncarry;
            r_ovf   <= (r_sign_a == r_sign_b) && (w_psum_next[W-1] != r_sign_a);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_suma_serie_nib.sv
// Bench for suma_serie_nib: directed cases plus random operands against an
// arithmetic reference (a + b + cin over W+1 bits).
module tb_suma_serie_nib;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  suma_serie_nib_if #(.NIB(NIB)) u_if ();

  suma_serie_nib #(.NIB(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // inj >= 0 pulses a conflicting start that many cycles after the accept edge.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input int inj);
    logic [W:0]   full;
    logic [W-1:0] prev_sum;
    int           busy_cnt;
    int           cyc;
    int           extra_done;
    full     = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
    prev_sum = u_if.sum;
    u_if.a     = ta;
    u_if.b     = tb;
    u_if.cin   = tcin;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    u_if.a     = W'($urandom);
    u_if.b     = W'($urandom);
    u_if.cin   = 1'($urandom);
    busy_cnt = 0;
    cyc      = 0;
    while (!u_if.done && cyc < 50) begin
      if (u_if.busy) busy_cnt++;
      if (u_if.sum !== prev_sum) begin
        fails++;
        $error("FAIL %s_sum_hold: observed %0h expected %0h", tag, u_if.sum, prev_sum);
      end
      u_if.start = (cyc == inj);
      if (cyc == inj) begin
        u_if.a = '1;
        u_if.b = '1;
      end
      step();
      u_if.start = 1'b0;
      cyc++;
    end
    chk({tag, "_done_seen"}, 64'(u_if.done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(NIB));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(NIB));
    chk({tag, "_sum"}, 64'(u_if.sum), 64'(full[W-1:0]));
    chk({tag, "_cout"}, 64'(u_if.cout), 64'(full[W]));
    chk({tag, "_ovf"}, 64'(u_if.ovf),
        64'((ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1])));
    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (u_if.done) extra_done++;
    end
    chk({tag, "_single_done"}, 64'(extra_done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(u_if.busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           done_cnt;
    tests = 0;
    fails = 0;
    u_if.start = 1'b0;
    u_if.a     = '0;
    u_if.b     = '0;
    u_if.cin   = 1'b0;
    reset      = 1'b1;
    step();
    step();
    chk("rst_busy", 64'(u_if.busy), 64'd0);
    chk("rst_done", 64'(u_if.done), 64'd0);
    chk("rst_sum",  64'(u_if.sum),  64'h0000);
    chk("rst_cout", 64'(u_if.cout), 64'd0);
    chk("rst_ovf",  64'(u_if.ovf),  64'd0);
    reset = 1'b0;
    step();

    run_op("basic",   16'h0001, 16'h000D, 1'b0, -1);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, -1);
    run_op("dddd",    16'hDDDD, 16'hDDDD, 1'b1, -1);
    run_op("ovf",     16'h7FFF, 16'h0001, 1'b0, -1);
    run_op("negovf",  16'h8000, 16'h8000, 1'b0, -1);
    run_op("busystart", 16'h0101, 16'h0202, 1'b0, 1);
    chk("busystart_exact", 64'(u_if.sum), 64'h0303);

    // Abort with reset on the second RUN edge.
    u_if.a     = 16'h1234;
    u_if.b     = 16'h1111;
    u_if.cin   = 1'b0;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("midrst_busy", 64'(u_if.busy), 64'd0);
    chk("midrst_sum",  64'(u_if.sum),  64'h0000);
    chk("midrst_done", 64'(u_if.done), 64'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (u_if.done) done_cnt++;
    end
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_sum_stays", 64'(u_if.sum), 64'h0000);
    run_op("after_rst", 16'h1234, 16'h1111, 1'b0, -1);
    chk("after_rst_exact", 64'(u_if.sum), 64'h2345);

    // Reset and start together: reset wins.
    u_if.start = 1'b1;
    reset      = 1'b1;
    step();
    u_if.start = 1'b0;
    reset      = 1'b0;
    chk("rst_start_busy", 64'(u_if.busy), 64'd0);
    step();

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op("rand", ra, rb, 1'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/suma_serie_nib.md
Name: suma_serie_nib

Overview:
Sequential multi-nibble adder that feeds the existing 4-bit ripple adder `sum4` one nibble per clock, LSB first. It chains the carry through a register, so a wide addition is built from the single 4-bit stage. It sits directly upstream of `sum4`, acting as its operand sequencer and result collector. It provides a start/busy/done handshake to the surrounding datapath.

Parameters:
NIB, 4, number of nibbles per operand (operand width W = 4*NIB); legal range 2..16.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  W  operand A, captured on the accepted start
b  input  W  operand B, captured on the accepted start
cin  input  1  carry-in, captured on the accepted start
busy  output  1  high while nibbles are being processed (RUN)
done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle on
sum  output  W  result, held until the next accepted start or reset
cout  output  1  carry out of the MSB nibble
ovf  output  1  two's-complement overflow of the W-bit sum

Behaviour:
- One clock domain. Reset is synchronous and active-high; it acts only on a rising clk edge.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, nibble counter=0, internal carry=0.
- FSM states and transitions:
  - IDLE: if start=1 at an edge, capture a, b and cin into operand shift registers, set counter=0, go to RUN. If start=0, stay in IDLE.
  - RUN: every edge the low nibbles of the operand registers and the carry register drive `sum4`.
    - The 4-bit result is shifted into the top of the partial-sum register. The operand registers shift right by 4. The carry register takes `sum4`'s carry-out. The counter increments.
    - After nibble NIB-1 is processed, go to DONE. On that same edge, load sum from the completed partial sum, cout from the final carry, and ovf.
  - DONE: done=1 for exactly this one cycle. The next edge returns to IDLE.
- Latency: start is accepted at edge T0. Nibbles are processed at edges T1..T_NIB. done is high in the cycle that follows edge T_NIB. busy is high from T0 until T_NIB.
- ovf = (A[W-1] == B[W-1]) and (sum[W-1] != A[W-1]), using the captured operands. cin takes part in the sum but not in the sign comparison.
- Arithmetic is modulo 2^W. The carry beyond bit W-1 appears only on cout.
- start while in RUN or DONE is ignored: no re-capture, and no extra done pulse.
- Input operands may change freely after the capture edge.
- Reset mid-operation: return to IDLE on that edge, clear all outputs, and suppress done. No partial result ever reaches sum.
- reset and start at the same edge: reset wins.
- sum, cout and ovf change only on the DONE-entry edge or on reset.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the nibble-width constant 4.
- Counter width is derived from NIB inside the module.
- One sub-module instance: the existing `sum4`, connected positionally as (sum, carry, a, b, cin). No other hierarchy.

Test Plan:
- Reset: hold reset for 2 cycles -> busy=0, done=0, sum=16'h0000, cout=0, ovf=0.
- Basic add, NIB=4: a=16'h0001, b=16'h000D, cin=0 with start for one cycle.
  -> busy high for 4 cycles, done pulses once in the 5th cycle after the start edge, sum=16'h000E, cout=0, ovf=0.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0. Then a=16'hDDDD, b=16'hDDDD, cin=1 -> sum=16'hBBBB, cout=1, ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
- Start while busy: start with a=16'h0101, b=16'h0202. Two cycles later, pulse start with a=16'hFFFF, b=16'hFFFF.
  -> a single done pulse, sum=16'h0303, and the second request is dropped.
- Reset mid-operation: start a=16'h1234, b=16'h1111, then assert reset at the 2nd RUN edge.
  -> busy=0 and sum=16'h0000 at once, no done pulse. A following start with the same operands yields sum=16'h2345.
